// File: rtl/apb_pad_cfg_ctrl.sv
// rtl/apb_pad_cfg_ctrl.sv - APB4 register block for per-pad configuration with sticky write-lock
//
// Purpose:
//   Holds the pad frame configuration vector (N_PADS x CFG_W). Four pads are
//   packed per 32-bit word, one pad per byte lane. A LOCK register freezes the
//   pad configuration until the next reset. cfg_upd_o pulses once after every
//   committed pad-config write that had at least one byte strobe set.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   paddr_i .. pstrb_i   APB4 request (address, select, enable, direction, data, strobes)
//   prdata_o, pready_o,  APB4 response, valid only while the FSM is in RESP
//   pslverr_o
//   pad_cfg_o            per-pad configuration driven straight into the pad frame
//   cfg_upd_o            one-cycle pulse the cycle after a committed pad-config write
//   lock_o               current lock state

module apb_pad_cfg_ctrl #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int N_PADS         = 48,
  parameter int CFG_W          = 6
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [APB_ADDR_WIDTH-1:0]     paddr_i,
  input  logic                          psel_i,
  input  logic                          penable_i,
  input  logic                          pwrite_i,
  input  logic [31:0]                   pwdata_i,
  input  logic [3:0]                    pstrb_i,
  output logic [31:0]                   prdata_o,
  output logic                          pready_o,
  output logic                          pslverr_o,
  output logic [N_PADS-1:0][CFG_W-1:0]  pad_cfg_o,
  output logic                          cfg_upd_o,
  output logic                          lock_o
);

  localparam int N_WORDS = N_PADS / 4;
  localparam int WW      = APB_ADDR_WIDTH - 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    state_q;
  logic [WW-1:0] word_q;
  logic          write_q;
  logic [31:0]   wdata_q;
  logic [3:0]    strb_q;

  logic          hit_cfg;
  logic          hit_lock;
  logic          err;
  logic          commit;
  logic [31:0]   rdata;
  logic          unused_bits;

  // Address bits [1:0] and the non-config bits of each byte lane carry no state.
  assign unused_bits = ^{paddr_i[1:0], wdata_q};

  always_comb begin
    hit_cfg  = int'(word_q) < N_WORDS;
    hit_lock = int'(word_q) == N_WORDS;
    // Unmapped addresses always fail; pad-config writes fail while locked.
    err      = !(hit_cfg || hit_lock) || (hit_cfg && write_q && lock_o);
    rdata    = '0;
    for (int p = 0; p < N_PADS; p++) begin
      if (hit_cfg && (p / 4) == int'(word_q)) begin
        rdata[8*(p%4) +: CFG_W] = pad_cfg_o[p];
      end
    end
    if (hit_lock) begin
      rdata[0] = lock_o;
    end
  end

  assign pready_o  = (state_q == S_RESP);
  assign pslverr_o = pready_o && err;
  assign prdata_o  = (pready_o && !write_q && !err) ? rdata : '0;
  assign commit    = pready_o && write_q && !err;

  // The request is captured in the setup phase so that the first access
  // cycle is the single wait state and pready rises in the second one.
  // Dropping psel in the wait state abandons the transfer without commit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (psel_i && !penable_i) begin
            state_q <= S_WAIT;
            word_q  <= paddr_i[APB_ADDR_WIDTH-1:2];
            write_q <= pwrite_i;
            wdata_q <= pwdata_i;
            strb_q  <= pstrb_i;
          end
        end
        S_WAIT:  state_q <= psel_i ? S_RESP : S_IDLE;
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pad_cfg_o <= '0;
      lock_o    <= 1'b0;
      cfg_upd_o <= 1'b0;
    end else begin
      // A rewrite of identical data still counts as an update.
      cfg_upd_o <= commit && hit_cfg && (|strb_q);
      if (commit && hit_lock && wdata_q[0]) begin
        lock_o <= 1'b1;
      end
      for (int p = 0; p < N_PADS; p++) begin
        if (commit && hit_cfg && (p / 4) == int'(word_q) && strb_q[p%4]) begin
          pad_cfg_o[p] <= wdata_q[8*(p%4) +: CFG_W];
        end
      end
    end
  end

endmodule
